// File: rtl/dec_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : dec_arbiter_if
// Purpose  : Bundles the request/grant handshake and the dual 2-to-4 decoder
//            strobes of dec_arbiter into one interface.
// Signals  : i_req[7:0] level requests, i_done grantee release,
//            o_a/o_b decoder selects, o_1c/o_1g bank 1 strobes,
//            o_2c/o_2g bank 2 strobes, o_gnt[7:0] one-hot grant,
//            o_busy arbiter not idle, o_tmo forced-release pulse.
// Modports : slave (the arbiter), master (the requesting side).
// Revision : 1.0 - initial release
// ============================================================================
interface dec_arbiter_if;
  logic [7:0] i_req;
  logic       i_done;
  logic       o_a;
  logic       o_b;
  logic       o_1c;
  logic       o_1g;
  logic       o_2c;
  logic       o_2g;
  logic [7:0] o_gnt;
  logic       o_busy;
  logic       o_tmo;

  modport slave (
    input  i_req, i_done,
    output o_a, o_b, o_1c, o_1g, o_2c, o_2g, o_gnt, o_busy, o_tmo
  );

  modport master (
    output i_req, i_done,
    input  o_a, o_b, o_1c, o_1g, o_2c, o_2g, o_gnt, o_busy, o_tmo
  );
endinterface
`default_nettype wire

// File: rtl/dec_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dec_arbiter
// Purpose  : 8-way round-robin arbiter driving two 2-to-4 decoder banks.
//            Requests 3:0 map to bank 1 outputs, 7:4 to bank 2 outputs.
//            Sequence per grant: IDLE -> SETUP -> GRANT -> RELEASE -> IDLE.
//            Select lines settle in SETUP, before any bank is enabled.
// Ports    : clk  - clock, rising edge
//            rst  - asynchronous active-high reset
//            bus  - dec_arbiter_if.slave (requests, done, decoder strobes,
//                   grant vector, busy, timeout pulse)
// Params   : HOLD_MAX - GRANT cycles before forced release (1..255)
// Macros   : ARB_TIMEOUT_EN - when defined, adds the hold counter and the
//            forced-release path; otherwise o_tmo is tied low.
// Revision : 1.0 - initial release
// ============================================================================
module dec_arbiter #(
  parameter int HOLD_MAX = 255
) (
  input  wire logic     clk,
  input  wire logic     rst,
  dec_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_SETUP   = 2'd1,
    S_GRANT   = 2'd2,
    S_RELEASE = 2'd3
  } state_t;

  if (HOLD_MAX < 1 || HOLD_MAX > 255) begin : g_hold_range_check
    $error("dec_arbiter: HOLD_MAX must be in 1..255");
  end

  state_t     r_state;
  logic [2:0] r_ptr;
  logic [2:0] r_idx;
  logic       r_a;
  logic       r_b;
  logic       r_1c;
  logic       r_1g;
  logic       r_2c;
  logic       r_2g;
  logic [7:0] r_gnt;
  logic       r_busy;

  logic [2:0] w_win;
  logic [2:0] w_cand;
  logic       w_any;
  logic       w_keep;
  logic       w_tmo_hit;

  // Round-robin pick: scan offsets 8 down to 1 so the nearest requester after
  // r_ptr is written last. Offset 8 wraps to r_ptr itself (lowest priority).
  always_comb begin
    w_win  = 3'd0;
    w_cand = 3'd0;
    for (int k = 8; k >= 1; k--) begin
      w_cand = r_ptr + 3'(k);
      if (bus.i_req[w_cand]) begin
        w_win = w_cand;
      end
    end
  end

  assign w_any  = |bus.i_req;
  // Grant persists only while the grantee still requests and has not released.
  assign w_keep = bus.i_req[r_idx] & ~bus.i_done;

`ifdef ARB_TIMEOUT_EN
  logic [7:0] r_cnt;
  logic       r_tmo;
  logic [7:0] w_cnt_nxt;

  assign w_cnt_nxt = r_cnt + 8'd1;
  assign w_tmo_hit = (w_cnt_nxt == 8'(HOLD_MAX));
  assign bus.o_tmo = r_tmo;
`else
  assign w_tmo_hit = 1'b0;
  assign bus.o_tmo = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_ptr   <= 3'd7;
      r_idx   <= 3'd0;
      r_a     <= 1'b0;
      r_b     <= 1'b0;
      r_1c    <= 1'b0;
      r_1g    <= 1'b1;
      r_2c    <= 1'b1;
      r_2g    <= 1'b1;
      r_gnt   <= 8'd0;
      r_busy  <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      r_cnt   <= 8'd0;
      r_tmo   <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_idx   <= w_win;
            r_a     <= w_win[0];
            r_b     <= w_win[1];
            r_busy  <= 1'b1;
            r_state <= S_SETUP;
          end
        end

        S_SETUP: begin
          r_gnt <= 8'd1 << r_idx;
          if (r_idx[2]) begin
            r_2c <= 1'b0;
            r_2g <= 1'b0;
          end else begin
            r_1c <= 1'b1;
            r_1g <= 1'b0;
          end
`ifdef ARB_TIMEOUT_EN
          r_cnt <= 8'd0;
`endif
          r_state <= S_GRANT;
        end

        S_GRANT: begin
          if (!w_keep || w_tmo_hit) begin
            r_gnt   <= 8'd0;
            r_1c    <= 1'b0;
            r_1g    <= 1'b1;
            r_2c    <= 1'b1;
            r_2g    <= 1'b1;
            r_state <= S_RELEASE;
`ifdef ARB_TIMEOUT_EN
            // A coincident normal release wins over the timeout.
            r_tmo   <= w_keep;
`endif
          end
`ifdef ARB_TIMEOUT_EN
          else begin
            r_cnt <= w_cnt_nxt;
          end
`endif
        end

        S_RELEASE: begin
          r_ptr   <= r_idx;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
`ifdef ARB_TIMEOUT_EN
          r_tmo   <= 1'b0;
`endif
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.o_a    = r_a;
  assign bus.o_b    = r_b;
  assign bus.o_1c   = r_1c;
  assign bus.o_1g   = r_1g;
  assign bus.o_2c   = r_2c;
  assign bus.o_2g   = r_2g;
  assign bus.o_gnt  = r_gnt;
  assign bus.o_busy = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_dec_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_dec_arbiter
// Purpose  : Self-checking bench for dec_arbiter. Stimulus pushes the expected
//            grantee into a queue; a negedge monitor pops it when a grant
//            appears and also checks bank/select/grant consistency each cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dec_arbiter;

`ifdef ARB_TIMEOUT_EN
  localparam int TB_HOLD_MAX = 3;
  localparam int RAND_HOLD   = 1;
`else
  localparam int TB_HOLD_MAX = 255;
  localparam int RAND_HOLD   = 3;
`endif

  logic clk;
  logic rst;
  dec_arbiter_if bus ();

  dec_arbiter #(.HOLD_MAX(TB_HOLD_MAX)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         total = 0;
  int         bad   = 0;
  logic [2:0] exp_q[$];
  logic [2:0] m_ptr;   // reference model: last granted index

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // First requester found scanning forward from the last grantee.
  function automatic logic [2:0] rr_pick(input logic [7:0] r, input logic [2:0] p);
    int pi;
    pi = int'(p);
    for (int k = 1; k <= 8; k++) begin
      if (r[(pi + k) % 8]) return 3'((pi + k) % 8);
    end
    return 3'd0;
  endfunction

  // ---------------- monitor ----------------
  logic [7:0] p_gnt;
  logic       p_en;
  logic [1:0] p_sel;

  always @(negedge clk) begin
    logic       b1, b2;
    logic [2:0] gi;
    logic [2:0] e;
    if (rst) begin
      p_gnt = 8'd0;
      p_en  = 1'b0;
      p_sel = 2'd0;
    end else begin
      b1 = bus.o_1c & ~bus.o_1g;
      b2 = ~bus.o_2c & ~bus.o_2g;
      gi = 3'd0;
      for (int k = 0; k < 8; k++) if (bus.o_gnt[k]) gi = 3'(k);
      chk("one_bank", {31'd0, b1 & b2}, 32'd0);
      chk("gnt_onehot", ($countones(bus.o_gnt) <= 1) ? 32'd1 : 32'd0, 32'd1);
      if (bus.o_gnt != 8'd0) begin
        chk("gnt_bank", {30'd0, b2, b1}, gi[2] ? 32'd2 : 32'd1);
        chk("gnt_sel", {30'd0, bus.o_b, bus.o_a}, {30'd0, gi[1:0]});
      end else begin
        chk("nogrant_nobank", {30'd0, b2, b1}, 32'd0);
      end
      if (p_en && (b1 | b2))
        chk("sel_stable", {30'd0, bus.o_b, bus.o_a}, {30'd0, p_sel});
      if (p_gnt != 8'd0 && bus.o_gnt != 8'd0)
        chk("gnt_stable", {24'd0, bus.o_gnt}, {24'd0, p_gnt});
      if (p_gnt == 8'd0 && bus.o_gnt != 8'd0) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL sb_unexpected: got gnt %0h expected none", bus.o_gnt);
        end else begin
          e = exp_q.pop_front();
          chk("sb_gnt", {24'd0, bus.o_gnt}, {24'd0, 8'd1 << e});
        end
      end
      p_gnt = bus.o_gnt;
      p_en  = b1 | b2;
      p_sel = {bus.o_b, bus.o_a};
    end
  end

  // ---------------- stimulus ----------------
  task automatic chk_reset_vals(input string nm);
    chk({nm, "_strobes"},
        {26'd0, bus.o_a, bus.o_b, bus.o_1c, bus.o_1g, bus.o_2c, bus.o_2g}, 32'b000111);
    chk({nm, "_gnt"}, {24'd0, bus.o_gnt}, 32'd0);
    chk({nm, "_busy_tmo"}, {30'd0, bus.o_busy, bus.o_tmo}, 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    #1 chk_reset_vals("reset");
    @(negedge clk);
    rst   = 1'b0;
    m_ptr = 3'd7;
  endtask

  // One grant transaction; called at a negedge with the arbiter idle.
  task automatic do_txn(input logic [7:0] pat, input int hold, input bit use_drop);
    logic [2:0] e;
    e = rr_pick(pat, m_ptr);
    exp_q.push_back(e);
    bus.i_req = pat;
    @(negedge clk);
    chk("setup_busy", {31'd0, bus.o_busy}, 32'd1);
    chk("setup_gnt", {24'd0, bus.o_gnt}, 32'd0);
    chk("setup_sel", {30'd0, bus.o_b, bus.o_a}, {30'd0, e[1:0]});
    @(negedge clk);
    chk("latency_gnt", {24'd0, bus.o_gnt}, {24'd0, 8'd1 << e});
    for (int h = 0; h < hold; h++) begin
      bus.i_req = 8'($urandom) | (8'd1 << e);
      @(negedge clk);
    end
    if (use_drop) bus.i_req[e] = 1'b0;
    else          bus.i_done   = 1'b1;
    @(negedge clk);
    chk("release_gnt", {24'd0, bus.o_gnt}, 32'd0);
    chk("release_busy_tmo", {30'd0, bus.o_busy, bus.o_tmo}, 32'd2);
    bus.i_done = 1'b0;
    bus.i_req  = 8'd0;
    m_ptr      = e;
    @(negedge clk);
    chk("idle_busy", {31'd0, bus.o_busy}, 32'd0);
    chk("idle_sel_hold", {30'd0, bus.o_b, bus.o_a}, {30'd0, e[1:0]});
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] pat;
    logic [2:0] e;
    rst        = 1'b1;
    bus.i_req  = 8'd0;
    bus.i_done = 1'b0;
    m_ptr      = 3'd7;
    #3 chk_reset_vals("por");
    @(negedge clk);
    rst = 1'b0;

    // single requester 0, release by done
    do_txn(8'h01, 0, 1'b0);

    // all requesting: order 0..7 then 0
    do_reset();
    for (int n = 0; n < 9; n++) do_txn(8'hFF, 0, 1'b0);

    // ptr to 4, then wrap path 7 then 4
    do_txn(8'h10, 0, 1'b0);
    do_txn(8'h90, 1, 1'b0);
    do_txn(8'h90, 0, 1'b0);

    // request drop ends grant of idx 5
    do_txn(8'h20, 2, 1'b1);

    // randomized traffic
    for (int n = 0; n < 30; n++) begin
      pat = 8'($urandom);
      if (pat == 8'd0) pat = 8'h01;
      do_txn(pat, int'($urandom_range(0, RAND_HOLD)), 1'($urandom_range(0, 1)));
    end

`ifdef ARB_TIMEOUT_EN
    // forced release after HOLD_MAX grant cycles
    e = rr_pick(8'h02, m_ptr);
    exp_q.push_back(e);
    bus.i_req = 8'h02;
    @(negedge clk);
    @(negedge clk);
    chk("tmo_gnt0", {24'd0, bus.o_gnt}, {24'd0, 8'd1 << e});
    @(negedge clk);
    chk("tmo_gnt1", {24'd0, bus.o_gnt}, {24'd0, 8'd1 << e});
    @(negedge clk);
    chk("tmo_gnt2", {24'd0, bus.o_gnt}, {24'd0, 8'd1 << e});
    @(negedge clk);
    chk("tmo_release", {23'd0, bus.o_tmo, bus.o_gnt}, 32'h100);
    bus.i_req = 8'd0;
    m_ptr     = e;
    @(negedge clk);
    chk("tmo_pulse_end", {30'd0, bus.o_busy, bus.o_tmo}, 32'd0);
    // done coincident with timeout is a normal release
    do_txn(8'h04, 2, 1'b0);
`else
    // no timeout: grant held for 1000 cycles
    do_txn(8'h08, 1000, 1'b0);
`endif

    // reset in the middle of a grant to idx 6
    e = rr_pick(8'h40, m_ptr);
    exp_q.push_back(e);
    bus.i_req = 8'h40;
    @(negedge clk);
    @(negedge clk);
    chk("midgrant_gnt", {24'd0, bus.o_gnt}, 32'h40);
    #2 rst = 1'b1;
    #1 chk_reset_vals("async_reset");
    @(negedge clk);
    bus.i_req = 8'd0;
    rst       = 1'b0;
    m_ptr     = 3'd7;
    do_txn(8'h41, 0, 1'b0);

    chk("queue_empty", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
